prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 43 ++++
 rtl/prog_loader_if.sv | 26 ++
 rtl/prog_loader_byte_packer.sv | 40 ++++
 rtl/prog_loader.sv | 114 +++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// LoaderPkg: shared types for the program loader.
//   ld_state_t : loader FSM states.
//   ld_ctrl_t  : registered control/status outputs, bundled so one value can
//                be assigned per state transition.
//   ctrl_for() : the output pattern that belongs to each state.
// ---------------------------------------------------------------------------
package LoaderPkg;

  typedef enum logic [2:0] {
    LdIdle,
    LdRecv,
    LdWrite,
    LdDone,
    LdErr
  } ld_state_t;

  typedef struct packed {
    logic byte_ready;
    logic mem_we;
    logic cpu_reset;
    logic busy;
    logic done;
    logic err;
  } ld_ctrl_t;

  function automatic ld_ctrl_t ctrl_for(ld_state_t s);
    ld_ctrl_t c;
    // NOTE: give every field a default before the case so no path leaves a
    // value unassigned; in combinational code that would infer a latch.
    c = '{byte_ready: 1'b0, mem_we: 1'b0, cpu_reset: 1'b1,
          busy: 1'b0, done: 1'b0, err: 1'b0};
    case (s)
      LdRecv:  begin c.byte_ready = 1'b1; c.busy = 1'b1; end
      LdWrite: begin c.mem_we = 1'b1; c.busy = 1'b1; end
      LdDone:  begin c.cpu_reset = 1'b0; c.done = 1'b1; end
      LdErr:   c.err = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if: byte-stream input and memory-write bus of the loader.
//   byte_in/byte_valid/byte_ready : valid/ready byte stream into the loader.
//   mem_we/mem_addr/mem_wdata     : word write port towards CPU memory.
// Modports:
//   slave  : the loader (consumes bytes, drives the memory bus).
//   master : the host/environment (supplies bytes, observes writes).
// ---------------------------------------------------------------------------
interface prog_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer: assembles four bytes into a big-endian 32-bit word.
//   clk, reset : clock, synchronous active-low reset.
//   clear      : restart assembly at byte 0.
//   shift_en   : a byte is accepted this cycle.
//   byte_in    : the byte being accepted.
//   word       : assembled word (first byte in bits 31:24).
//   word_full  : the byte accepted this cycle is the 4th of a word.
// ---------------------------------------------------------------------------
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_idx;

  always_ff @(posedge clk) begin
    // NOTE: the shift register is a handful of flops, not a RAM, so it is
    // reset along with the counter to give a defined word after reset.
    if (!reset) begin
      byte_idx <= 2'd0;
      word     <= 32'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
    end else if (shift_en) begin
      // NOTE: non-blocking so byte_idx and word both see pre-edge values.
      byte_idx <= byte_idx + 2'd1;
      word     <= {word[23:0], byte_in};
    end
  end

  // The counter wraps to 0 on the 4th byte, so the next word starts clean.
  assign word_full = shift_en && (byte_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader: receives a program as a byte stream, packs it into 32-bit
// words and writes them to CPU memory, holding the CPU in reset until the
// whole program is in place.
//   clk, reset  : clock, synchronous active-low reset.
//   start       : one-cycle load request (honoured in IDLE, DONE, ERR).
//   word_count  : words to load, sampled with an accepted start.
//   bus         : byte stream in, memory write bus out (slave modport).
//   cpu_reset   : high while no complete program is loaded.
//   busy        : load in progress.
//   done        : load complete, CPU released.
//   err         : last start carried an illegal word_count.
// ---------------------------------------------------------------------------
module prog_loader
  import LoaderPkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  prog_loader_if.slave bus,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  ld_state_t   state;
  ld_ctrl_t    ctrl;
  logic [15:0] word_idx;
  logic [15:0] word_cnt;
  logic [31:0] addr_q;
  logic [31:0] word;
  logic        word_full;
  logic        xfer;
  logic        start_ok;

  assign xfer     = bus.byte_valid && ctrl.byte_ready;
  assign start_ok = start && (state == LdIdle || state == LdDone || state == LdErr);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .shift_en  (xfer),
    .byte_in   (bus.byte_in),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= LdIdle;
      ctrl     <= ctrl_for(LdIdle);
      word_idx <= 16'd0;
      word_cnt <= 16'd0;
      addr_q   <= 32'd0;
    end else begin
      case (state)
        LdIdle, LdDone, LdErr: begin
          if (start) begin
            word_cnt <= word_count;
            word_idx <= 16'd0;
            if (word_count == 16'd0) begin
              state <= LdDone;
              ctrl  <= ctrl_for(LdDone);
            end else if (32'(word_count) > MEM_DEPTH) begin
              state <= LdErr;
              ctrl  <= ctrl_for(LdErr);
            end else begin
              state <= LdRecv;
              ctrl  <= ctrl_for(LdRecv);
            end
          end
        end
        LdRecv: begin
          if (xfer && word_full) begin
            state  <= LdWrite;
            ctrl   <= ctrl_for(LdWrite);
            addr_q <= {14'd0, word_idx, 2'b00};
          end
        end
        LdWrite: begin
          word_idx <= word_idx + 16'd1;
          if (word_idx + 16'd1 == word_cnt) begin
            state <= LdDone;
            ctrl  <= ctrl_for(LdDone);
          end else begin
            state <= LdRecv;
            ctrl  <= ctrl_for(LdRecv);
          end
        end
        default: begin
          state <= LdIdle;
          ctrl  <= ctrl_for(LdIdle);
        end
      endcase
    end
  end

  assign bus.byte_ready = ctrl.byte_ready;
  // A WRITE cycle during which reset is already low is being abandoned, so
  // its strobe is suppressed rather than letting a half-load reach memory.
  assign bus.mem_we     = ctrl.mem_we && reset;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = word;
  assign cpu_reset      = ctrl.cpu_reset;
  assign busy           = ctrl.busy;
  assign done           = ctrl.done;
  assign err            = ctrl.err;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader: directed self-checking bench for prog_loader.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        cpu_reset, busy, done, err;

  prog_loader_if lif ();

  prog_loader #(.MEM_DEPTH(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (lif),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  // Capture every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (lif.mem_we === 1'b1) begin
      wr_addr_q.push_back(lif.mem_addr);
      wr_data_q.push_back(lif.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end at posedge + #1.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
  endtask

  task automatic pulse_start(input logic [15:0] cnt);
    start      = 1'b1;
    word_count = cnt;
    cycles(1);
    start      = 1'b0;
  endtask

  // Offer one byte and wait (bounded) until it is accepted; byte_valid is
  // left high so back-to-back calls form a gap-free stream.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    lif.byte_in    = b;
    lif.byte_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (lif.byte_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] prog8 [8];
    logic [7:0] tog_bytes [4];
    bit         pat [7];
    int         idx;
    int         errs;
    int         base;

    prog8     = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    tog_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    lif.byte_in    = 8'h00;
    lif.byte_valid = 1'b0;
    cycles(1);
    apply_reset();

    // Reset state.
    check("rst_cpu_reset",  32'(cpu_reset),      32'd1);
    check("rst_byte_ready", 32'(lif.byte_ready), 32'd0);
    check("rst_mem_we",     32'(lif.mem_we),     32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_done",       32'(done),           32'd0);
    check("rst_err",        32'(err),            32'd0);

    // Two-word gap-free load.
    pulse_start(16'd2);
    check("load2_busy",  32'(busy),           32'd1);
    check("load2_ready", 32'(lif.byte_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(prog8[i]);
    check("load2_w0_we",   32'(lif.mem_we), 32'd1);
    check("load2_w0_addr", lif.mem_addr,    32'h0000_0000);
    check("load2_w0_data", lif.mem_wdata,   32'h2008_0005);
    check("load2_w0_cpu_reset", 32'(cpu_reset), 32'd1);
    for (int i = 4; i < 8; i++) send_byte(prog8[i]);
    check("load2_w1_we",   32'(lif.mem_we), 32'd1);
    check("load2_w1_addr", lif.mem_addr,    32'h0000_0004);
    check("load2_w1_data", lif.mem_wdata,   32'h8C09_0004);
    lif.byte_valid = 1'b0;
    cycles(1);
    check("load2_done",      32'(done),      32'd1);
    check("load2_cpu_reset", 32'(cpu_reset), 32'd0);
    check("load2_busy_off",  32'(busy),      32'd0);
    check("load2_nwrites",   32'(wr_addr_q.size()), 32'd2);

    // One word with byte_valid toggling 1,0,0,1,1,0,1.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd1);
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      lif.byte_valid = pat[i];
      lif.byte_in    = tog_bytes[(idx < 4) ? idx : 3];
      @(negedge clk);
      if (lif.byte_valid && lif.byte_ready) idx++;
      @(posedge clk);
      #1;
    end
    lif.byte_valid = 1'b0;
    cycles(2);
    check("tog_accepted", 32'(idx),               32'd4);
    check("tog_nwrites",  32'(wr_addr_q.size()),  32'd1);
    check("tog_addr",     wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("tog_data",     wr_data_q.size() > 0 ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h1234_5678);
    check("tog_done",     32'(done),              32'd1);

    // word_count over MEM_DEPTH, then zero, then zero from IDLE.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd1025);
    check("over_err",       32'(err),            32'd1);
    check("over_cpu_reset", 32'(cpu_reset),      32'd1);
    check("over_ready",     32'(lif.byte_ready), 32'd0);
    check("over_done",      32'(done),           32'd0);
    pulse_start(16'd0);
    check("zero_done",      32'(done),      32'd1);
    check("zero_err_clr",   32'(err),       32'd0);
    check("zero_cpu_reset", 32'(cpu_reset), 32'd0);
    apply_reset();
    pulse_start(16'd0);
    check("zero_idle_done", 32'(done), 32'd1);
    check("zero_nwrites",   32'(wr_addr_q.size()), 32'd0);

    // Reset after 6 of 8 bytes, then a fresh one-word load.
    pulse_start(16'd2);
    for (int i = 0; i < 6; i++) send_byte(prog8[i]);
    lif.byte_valid = 1'b0;
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    check("midrst_cpu_reset", 32'(cpu_reset),      32'd1);
    check("midrst_busy",      32'(busy),           32'd0);
    check("midrst_ready",     32'(lif.byte_ready), 32'd0);
    check("midrst_nwrites",   32'(wr_addr_q.size()), 32'd1);
    pulse_start(16'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    lif.byte_valid = 1'b0;
    cycles(2);
    check("reload_nwrites", 32'(wr_addr_q.size()), 32'd2);
    check("reload_addr", wr_addr_q.size() > 1 ? wr_addr_q[1] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("reload_data", wr_data_q.size() > 1 ? wr_data_q[1] : 32'hDEAD_BEEF, 32'hAABB_CCDD);

    // Reset landing on the WRITE cycle must not strobe memory.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    lif.byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("wrrst_mem_we", 32'(lif.mem_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycles(1);
    check("wrrst_nwrites", 32'(wr_addr_q.size()), 32'd0);
    check("wrrst_cpu_reset", 32'(cpu_reset), 32'd1);

    // Full-depth load with a stray start during RECV.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start(16'd1024);
    send_byte(8'h00);
    lif.byte_valid = 1'b0;
    pulse_start(16'd3);
    check("stray_busy", 32'(busy), 32'd1);
    for (int k = 1; k < 4096; k++) send_byte(k[7:0]);
    lif.byte_valid = 1'b0;
    cycles(2);
    check("full_nwrites", 32'(wr_addr_q.size()), 32'd1024);
    errs = 0;
    for (int i = 0; i < wr_addr_q.size() && i < 1024; i++) begin
      base = 4 * i;
      if (wr_addr_q[i] !== 32'(base)) errs++;
      if (wr_data_q[i] !== {8'(base), 8'(base + 1), 8'(base + 2), 8'(base + 3)}) errs++;
    end
    check("full_seq_errs", 32'(errs), 32'd0);
    check("full_last_addr", wr_addr_q.size() > 0 ? wr_addr_q[wr_addr_q.size()-1] : 32'hDEAD_BEEF, 32'h0000_0FFC);
    check("full_last_data", wr_data_q.size() > 0 ? wr_data_q[wr_data_q.size()-1] : 32'hDEAD_BEEF, 32'hFCFD_FEFF);
    check("full_done",      32'(done),      32'd1);
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
